// File: rtl/axi4lite_ctrl_slave.sv
// AXI4-Lite control/status slave: start handshake, sticky W1C done flags,
// byte-strobed scratch, coherent counter snapshots. Optional irq via AXI_CTRL_IRQ_EN.
module axi4lite_ctrl_slave #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_ADDR_WIDTH = 8,
  parameter int PERF_CNTR_WIDTH = 32,
  parameter int NUM_CNTR        = 4,
  parameter int NUM_SCRATCH     = 4
) (
  input  logic                                S_AXI_ACLK,
  input  logic                                S_AXI_ARESET,
  input  logic [AXIS_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                          S_AXI_AWPROT,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [AXIS_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [AXIS_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [AXIS_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                          S_AXI_ARPROT,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  output logic [AXIS_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  output logic                                tx_req,
  input  logic                                tx_done,
  input  logic                                rd_done,
  input  logic                                processing_done,
  input  logic                                wr_done,
  input  logic [NUM_CNTR*PERF_CNTR_WIDTH-1:0] perf_cntr_in
`ifdef AXI_CTRL_IRQ_EN
  ,
  output logic                                irq
`endif
);

  localparam int WORD_W = AXIS_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [WORD_W-1:0] IDX_CTRL   = WORD_W'(0);
  localparam logic [WORD_W-1:0] IDX_STATUS = WORD_W'(1);
  localparam logic [WORD_W-1:0] IDX_ID     = WORD_W'(2);
  localparam logic [WORD_W-1:0] IDX_SCR    = WORD_W'(4);
  localparam logic [WORD_W-1:0] IDX_CNTR   = WORD_W'(16);
  localparam logic [31:0] ID_VALUE = 32'h4158_0000 | (32'(NUM_CNTR) << 8) | 32'(NUM_SCRATCH);

  typedef enum logic {CH_IDLE = 1'b0, CH_RESP = 1'b1} ch_state_e;

  ch_state_e wr_state_r, wr_state_s;
  ch_state_e rd_state_r, rd_state_s;

  logic [WORD_W-1:0]          wr_idx_s, rd_idx_s;
  logic                       wr_accept_s, rd_accept_s;
  logic                       wr_ctrl_s, start_s;
  logic [3:0]                 w1c_s, set_s;
  logic [3:0]                 flags_r;
  logic                       tx_req_r;
  logic                       irq_en_s;
  logic [1:0]                 bresp_r, rresp_r, rd_resp_s;
  logic [31:0]                rdata_r, rd_data_s;
  logic [31:0]                scratch_r [NUM_SCRATCH];
  logic [PERF_CNTR_WIDTH-1:0] snap_r    [NUM_CNTR];
  logic                       unused_s;

  function automatic logic idx_mapped(input logic [WORD_W-1:0] idx);
    logic hit;
    hit = (idx == IDX_CTRL) | (idx == IDX_STATUS) | (idx == IDX_ID);
    for (int k = 0; k < NUM_SCRATCH; k++) hit = hit | (idx == IDX_SCR + WORD_W'(k));
    for (int i = 0; i < NUM_CNTR; i++) hit = hit | (idx == IDX_CNTR + WORD_W'(i));
    return hit;
  endfunction

  assign wr_idx_s    = S_AXI_AWADDR[AXIS_ADDR_WIDTH-1:2];
  assign rd_idx_s    = S_AXI_ARADDR[AXIS_ADDR_WIDTH-1:2];
  assign wr_accept_s = S_AXI_AWVALID & S_AXI_WVALID & (wr_state_r == CH_IDLE);
  assign rd_accept_s = S_AXI_ARVALID & (rd_state_r == CH_IDLE);

  assign S_AXI_AWREADY = wr_accept_s;
  assign S_AXI_WREADY  = wr_accept_s;
  assign S_AXI_BVALID  = (wr_state_r == CH_RESP);
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = rd_accept_s;
  assign S_AXI_RVALID  = (rd_state_r == CH_RESP);
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign tx_req        = tx_req_r;

  assign wr_ctrl_s = wr_accept_s & (wr_idx_s == IDX_CTRL) & S_AXI_WSTRB[0];
  assign start_s   = wr_ctrl_s & S_AXI_WDATA[0];
  assign w1c_s     = (wr_accept_s & (wr_idx_s == IDX_STATUS) & S_AXI_WSTRB[0]) ? S_AXI_WDATA[4:1] : 4'd0;
  assign set_s     = {tx_done, wr_done, processing_done, rd_done};

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Channel state registers
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_state_r <= CH_IDLE;
      rd_state_r <= CH_IDLE;
    end else begin
      wr_state_r <= wr_state_s;
      rd_state_r <= rd_state_s;
    end
  end

  // Channel next-state: accept, then hold the response until the master takes it
  always_comb begin
    wr_state_s = wr_state_r;
    rd_state_s = rd_state_r;
    case (wr_state_r)
      CH_IDLE: if (wr_accept_s) wr_state_s = CH_RESP; else wr_state_s = CH_IDLE;
      CH_RESP: if (S_AXI_BREADY) wr_state_s = CH_IDLE; else wr_state_s = CH_RESP;
      default: wr_state_s = CH_IDLE;
    endcase
    case (rd_state_r)
      CH_IDLE: if (rd_accept_s) rd_state_s = CH_RESP; else rd_state_s = CH_IDLE;
      CH_RESP: if (S_AXI_RREADY) rd_state_s = CH_IDLE; else rd_state_s = CH_RESP;
      default: rd_state_s = CH_IDLE;
    endcase
  end

  // Read mux; the scratch/counter windows are OR-combined one-hot hits
  always_comb begin
    rd_data_s = 32'd0;
    rd_resp_s = idx_mapped(rd_idx_s) ? RESP_OKAY : RESP_SLVERR;
    if (rd_idx_s == IDX_CTRL) begin
      rd_data_s = {30'd0, irq_en_s, 1'b0};
    end else if (rd_idx_s == IDX_STATUS) begin
      rd_data_s = {27'd0, flags_r, tx_req_r};
    end else if (rd_idx_s == IDX_ID) begin
      rd_data_s = ID_VALUE;
    end else begin
      for (int k = 0; k < NUM_SCRATCH; k++)
        rd_data_s = rd_data_s | ({32{rd_idx_s == IDX_SCR + WORD_W'(k)}} & scratch_r[k]);
      for (int i = 0; i < NUM_CNTR; i++)
        rd_data_s = rd_data_s | ({32{rd_idx_s == IDX_CNTR + WORD_W'(i)}} & 32'(snap_r[i]));
    end
  end

  // Response payload registers, captured at acceptance
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      bresp_r <= RESP_OKAY;
      rresp_r <= RESP_OKAY;
      rdata_r <= 32'd0;
    end else begin
      if (wr_accept_s) bresp_r <= idx_mapped(wr_idx_s) ? RESP_OKAY : RESP_SLVERR;
      if (rd_accept_s) begin
        rdata_r <= rd_data_s;
        rresp_r <= rd_resp_s;
      end
    end
  end

  // Control state: start handshake, sticky flags (set beats W1C), scratch, snapshots
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      tx_req_r <= 1'b0;
      flags_r  <= 4'd0;
      for (int k = 0; k < NUM_SCRATCH; k++) scratch_r[k] <= 32'd0;
      for (int i = 0; i < NUM_CNTR; i++) snap_r[i] <= PERF_CNTR_WIDTH'(0);
    end else begin
      if (tx_req_r) begin
        if (tx_done) tx_req_r <= 1'b0;
      end else if (start_s) begin
        tx_req_r <= 1'b1;
      end
      flags_r <= set_s | (flags_r & ~w1c_s);
      for (int k = 0; k < NUM_SCRATCH; k++) begin
        if (wr_accept_s && (wr_idx_s == IDX_SCR + WORD_W'(k))) begin
          for (int b = 0; b < 4; b++)
            if (S_AXI_WSTRB[b]) scratch_r[k][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
      if (tx_done) begin
        for (int i = 0; i < NUM_CNTR; i++)
          snap_r[i] <= perf_cntr_in[i*PERF_CNTR_WIDTH +: PERF_CNTR_WIDTH];
      end
    end
  end

`ifdef AXI_CTRL_IRQ_EN
  logic irq_en_r, irq_r;

  // Interrupt enable and level interrupt, one cycle behind its terms
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (wr_ctrl_s) irq_en_r <= S_AXI_WDATA[1];
      irq_r <= irq_en_r & flags_r[3];
    end
  end

  assign irq_en_s = irq_en_r;
  assign irq      = irq_r;
`else
  assign irq_en_s = 1'b0;
`endif

endmodule

// File: tb/tb_axi4lite_ctrl_slave.sv
// Directed self-checking bench for axi4lite_ctrl_slave (default parameters).
module tb_axi4lite_ctrl_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         tx_req, tx_done, rd_done, pr_done, wr_done;
  logic [127:0] perf;
  logic         irq_w;
  logic [3:0]   acc_pulse;
  logic         txreq_after_aw, irq_after_aw;
  logic [31:0]  d;
  logic [1:0]   r;
  int           total = 0;
  int           bad = 0;

`ifdef AXI_CTRL_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'h0000_0002;
`else
  localparam logic [31:0] CTRL_RB = 32'h0000_0000;
  assign irq_w = 1'b0;
`endif

  always #5 clk = ~clk;

  axi4lite_ctrl_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .tx_req(tx_req), .tx_done(tx_done), .rd_done(rd_done), .processing_done(pr_done),
    .wr_done(wr_done), .perf_cntr_in(perf)
`ifdef AXI_CTRL_IRQ_EN
    , .irq(irq_w)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] p);
    {tx_done, wr_done, pr_done, rd_done} = p;
    @(posedge clk); #1;
    {tx_done, wr_done, pr_done, rd_done} = 4'b0000;
  endtask

  // acc_pulse drives the done inputs in the address-acceptance cycle
  task automatic axi_write(input logic [7:0] a, input logic [31:0] dat, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    n = 0;
    awaddr = a; wdata = dat; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; #1;
    while (!(awready && wready) && n < 20) begin @(posedge clk); #1; n++; end
    check_val("aw_handshake", {31'd0, awready & wready}, 32'd1);
    {tx_done, wr_done, pr_done, rd_done} = acc_pulse;
    @(posedge clk); #1;
    {tx_done, wr_done, pr_done, rd_done} = 4'b0000;
    awvalid = 1'b0; wvalid = 1'b0;
    txreq_after_aw = tx_req;
    irq_after_aw = irq_w;
    n = 0; bready = 1'b1;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    check_val("b_handshake", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] dat, output logic [1:0] resp);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1; #1;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    check_val("ar_handshake", {31'd0, arready}, 32'd1);
    {tx_done, wr_done, pr_done, rd_done} = acc_pulse;
    @(posedge clk); #1;
    {tx_done, wr_done, pr_done, rd_done} = 4'b0000;
    arvalid = 1'b0;
    n = 0; rready = 1'b1;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    check_val("r_handshake", {31'd0, rvalid}, 32'd1);
    dat = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; awaddr = 8'h00; araddr = 8'h00; awprot = 3'b000; arprot = 3'b000;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = 32'd0; wstrb = 4'h0; tx_done = 1'b0; rd_done = 1'b0; pr_done = 1'b0; wr_done = 1'b0;
    perf = 128'd0; acc_pulse = 4'b0000; txreq_after_aw = 1'b0; irq_after_aw = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_val("rst_txreq", {31'd0, tx_req}, 32'd0);
    check_val("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check_val("rst_rvalid", {31'd0, rvalid}, 32'd0);
    axi_read(8'h08, d, r); check_val("id_data", d, 32'h4158_0404); check_val("id_resp", {30'd0, r}, 32'd0);
    axi_read(8'h00, d, r); check_val("ctrl_rst", d, 32'd0);
    axi_read(8'h04, d, r); check_val("status_rst", d, 32'd0);

    // start handshake and snapshot capture
    axi_write(8'h00, 32'h1, 4'hF, r);
    check_val("start_resp", {30'd0, r}, 32'd0);
    check_val("txreq_latency", {31'd0, txreq_after_aw}, 32'd1);
    perf = {32'h0000_4444, 32'h0000_1234, 32'h0000_2222, 32'h0000_1111};
    pulse(4'b1000);
    check_val("txreq_clear", {31'd0, tx_req}, 32'd0);
    axi_read(8'h04, d, r); check_val("status_txdone", d, 32'h10);
    axi_read(8'h48, d, r); check_val("cntr2", d, 32'h1234); check_val("cntr2_resp", {30'd0, r}, 32'd0);
    perf = {32'hDEAD_0003, 32'h0000_BEEF, 32'hDEAD_0001, 32'hDEAD_0000};
    axi_read(8'h48, d, r); check_val("cntr2_hold", d, 32'h1234);
    axi_read(8'h40, d, r); check_val("cntr0", d, 32'h1111);

    // START while busy is ignored but answered OKAY
    axi_write(8'h00, 32'h1, 4'hF, r);
    check_val("busy_start1", {31'd0, tx_req}, 32'd1);
    axi_write(8'h00, 32'h1, 4'hF, r);
    check_val("busy_start_resp", {30'd0, r}, 32'd0);
    check_val("busy_start_txreq", {31'd0, tx_req}, 32'd1);
    pulse(4'b1000);
    check_val("txreq_clear2", {31'd0, tx_req}, 32'd0);
    axi_read(8'h48, d, r); check_val("cntr2_reload", d, 32'h0000_BEEF);

    // scratch with byte strobes
    axi_write(8'h10, 32'h0, 4'hF, r);
    axi_write(8'h10, 32'hAABB_CCDD, 4'b0101, r);
    axi_read(8'h10, d, r); check_val("scr0_strb", d, 32'h00BB_00DD);
    axi_write(8'h1C, 32'h5A5A_5A5A, 4'hF, r); check_val("scr3_resp", {30'd0, r}, 32'd0);
    axi_read(8'h1C, d, r); check_val("scr3", d, 32'h5A5A_5A5A);
    axi_read(8'h14, d, r); check_val("scr1_untouched", d, 32'd0);

    // decode errors
    axi_read(8'h3C, d, r); check_val("rd_3c_data", d, 32'd0); check_val("rd_3c_resp", {30'd0, r}, 32'd2);
    axi_write(8'h7C, 32'hFFFF_FFFF, 4'hF, r); check_val("wr_7c_resp", {30'd0, r}, 32'd2);
    axi_read(8'h0C, d, r); check_val("rd_0c_resp", {30'd0, r}, 32'd2);
    axi_read(8'h50, d, r); check_val("rd_50_resp", {30'd0, r}, 32'd2);
    axi_read(8'h20, d, r); check_val("rd_20_resp", {30'd0, r}, 32'd2);
    axi_write(8'h08, 32'h0, 4'hF, r); check_val("wr_id_resp", {30'd0, r}, 32'd0);
    axi_read(8'h08, d, r); check_val("id_after_wr", d, 32'h4158_0404);

    // sticky flags and W1C
    axi_write(8'h04, 32'h1E, 4'hF, r);
    axi_read(8'h04, d, r); check_val("w1c_all", d, 32'd0);
    pulse(4'b0001);
    axi_read(8'h04, d, r); check_val("rd_done_set", d, 32'h02);
    acc_pulse = 4'b0001;
    axi_write(8'h04, 32'h02, 4'hF, r);
    acc_pulse = 4'b0000;
    axi_read(8'h04, d, r); check_val("set_beats_w1c", d, 32'h02);
    axi_write(8'h04, 32'h02, 4'hF, r);
    axi_read(8'h04, d, r); check_val("w1c_rd", d, 32'd0);
    acc_pulse = 4'b0100;
    axi_read(8'h04, d, r); check_val("read_preset", d, 32'd0);
    acc_pulse = 4'b0000;
    axi_read(8'h04, d, r); check_val("wr_done_set", d, 32'h08);
    pulse(4'b0010);
    axi_read(8'h04, d, r); check_val("pr_done_set", d, 32'h0C);
    axi_write(8'h04, 32'h1E, 4'hF, r);
    pulse(4'b1000);
    axi_read(8'h04, d, r); check_val("txdone_idle", d, 32'h10);

    // CTRL readback: START reads 0, IRQ_EN only when the feature is built
    axi_write(8'h00, 32'h2, 4'hF, r);
    axi_read(8'h00, d, r); check_val("ctrl_rb", d, CTRL_RB);
    check_val("ctrl_nostart", {31'd0, tx_req}, 32'd0);

`ifdef AXI_CTRL_IRQ_EN
    axi_write(8'h04, 32'h10, 4'hF, r);
    check_val("irq_off", {31'd0, irq_w}, 32'd0);
    axi_write(8'h00, 32'h3, 4'hF, r);
    pulse(4'b1000);
    check_val("irq_lag", {31'd0, irq_w}, 32'd0);
    @(posedge clk); #1;
    check_val("irq_on", {31'd0, irq_w}, 32'd1);
    axi_write(8'h04, 32'h10, 4'hF, r);
    check_val("irq_hold_w1c_edge", {31'd0, irq_after_aw}, 32'd1);
    check_val("irq_cleared", {31'd0, irq_w}, 32'd0);
`endif

    // BREADY held low: response holds, no new AW accepted
    awaddr = 8'h10; wdata = 32'h1111_1111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; #1;
    check_val("hold_first_ready", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    wdata = 32'h2222_2222;
    for (int i = 0; i < 5; i++) begin
      check_val("hold_bvalid", {31'd0, bvalid}, 32'd1);
      check_val("hold_no_aw", {31'd0, awready}, 32'd0);
      check_val("hold_bresp", {30'd0, bresp}, 32'd0);
      @(posedge clk); #1;
    end
    axi_read(8'h10, d, r); check_val("hold_read_indep", d, 32'h1111_1111);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_val("hold_release", {31'd0, bvalid}, 32'd0);
    check_val("second_aw_ready", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(8'h10, d, r); check_val("second_write", d, 32'h2222_2222);

    // reset mid-transaction
    axi_write(8'h00, 32'h1, 4'hF, r);
    awaddr = 8'h14; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check_val("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
    rst = 1'b1; #1;
    check_val("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
    check_val("mid_rst_txreq", {31'd0, tx_req}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    axi_read(8'h14, d, r); check_val("post_rst_scr1", d, 32'd0);
    axi_read(8'h48, d, r); check_val("post_rst_cntr2", d, 32'd0);
    axi_read(8'h04, d, r); check_val("post_rst_status", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4lite_ctrl_slave.md
# axi4lite_ctrl_slave

Parametrised AXI4-Lite control/status slave for the accelerator shell. It is the successor to the fixed four-counter control slave. It issues a level `tx_req` start handshake to the datapath and keeps sticky write-1-to-clear done flags. It also provides NUM_CNTR coherent performance-counter snapshots, byte-strobed scratch registers and SLVERR decoding. It sits between the host AXI4-Lite interconnect and the accelerator top-level control FSM.

## Interface
- `AXIS_DATA_WIDTH`, 32, AXI data width. Only 32 is supported.
- `AXIS_ADDR_WIDTH`, 8, byte address width. Must satisfy 2^AXIS_ADDR_WIDTH ≥ 0x40 + 4·NUM_CNTR.
- `PERF_CNTR_WIDTH`, 32, width of each counter. Must be ≤ AXIS_DATA_WIDTH; reads zero-extend.
- `NUM_CNTR`, 4, number of performance counters, 1..16.
- `NUM_SCRATCH`, 4, number of scratch registers, 1..8.
- `S_AXI_ACLK` in 1: clock.
- `S_AXI_ARESET` in 1: asynchronous, active-high reset.
- `S_AXI_AW{ADDR,PROT,VALID}` in, `S_AXI_AWREADY` out: write address channel (ADDR AXIS_ADDR_WIDTH, PROT 3).
- `S_AXI_W{DATA,STRB,VALID}` in, `S_AXI_WREADY` out: write data channel.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1: write response channel.
- `S_AXI_AR{ADDR,PROT,VALID}` in, `S_AXI_ARREADY` out: read address channel.
- `S_AXI_RDATA` out 32, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1: read data channel.
- `tx_req` out 1: start request, level.
- `tx_done` in 1: single-cycle pulse.
- `rd_done`, `processing_done`, `wr_done` in 1: single-cycle phase-completion pulses.
- `perf_cntr_in` in NUM_CNTR·PERF_CNTR_WIDTH: live counters, counter i at bits [i·W +: W].
- `irq` out 1: interrupt, present only with AXI_CTRL_IRQ_EN.

## Operation
Register map (byte addresses, word aligned; ADDR[1:0] ignored):
- 0x00 CTRL.
  - bit0 START: write-only, self-clearing, reads 0.
  - bit1 IRQ_EN: read/write.
- 0x04 STATUS, all read-only except the W1C bits.
  - bit0 BUSY (= tx_req).
  - bits 1–4 are sticky RD_DONE, PR_DONE, WR_DONE, TX_DONE; each is write-1-to-clear.
- 0x08 ID: constant 0x4158_0000 | NUM_CNTR<<8 | NUM_SCRATCH.
- 0x10 + 4·k SCRATCH[k]: read/write, byte-strobed.
- 0x40 + 4·i CNTR[i]: read-only snapshot.

Any other address:
- Reads return RDATA=0 with RRESP=SLVERR (2'b10).
- Writes have no effect and return BRESP=SLVERR.
- All mapped accesses return OKAY.

Start handshake:
- A write with START=1 while BUSY=0 sets `tx_req` on the next cycle.
- `tx_req` holds high until the cycle `tx_done` is sampled high, then clears on the following edge.
- START while BUSY=1 is ignored, with BRESP OKAY.

Sticky flags:
- Each done input pulse sets its flag.
- If a set pulse and a W1C land in the same cycle, set wins.
- A `tx_done` pulse with BUSY=0 still sets TX_DONE.

Snapshots:
- All NUM_CNTR snapshots load from `perf_cntr_in` in the cycle `tx_done` is sampled high, so reads stay coherent after completion.
- A snapshot holds until the next `tx_done`.

Reset: CTRL, STATUS flags, scratch, snapshots, `tx_req` and `irq` all clear to 0 asynchronously.

## Timing
Write channel:
- AW and W are accepted together only when AWVALID & WVALID & !BVALID.
- AWREADY and WREADY pulse high for one cycle on acceptance.
- The register update takes effect on that same edge.
- BVALID rises on the next edge and holds, with BRESP stable, until BREADY.

Read channel:
- ARREADY pulses for one cycle when ARVALID & !RVALID.
- RVALID rises on the next edge, with RDATA/RRESP registered from the address and state at acceptance.
- RDATA and RRESP hold until RREADY.

General:
- Maximum throughput is one transaction per two cycles per channel.
- Read and write channels are independent.
- A read of STATUS in the same cycle as a flag set returns the pre-set value.
- `tx_req` latency from the START write edge is 1 cycle.
- Reset asserted mid-transaction drops all VALID and READY outputs immediately. The pending response is lost.

## Configuration
- `AXI_CTRL_IRQ_EN` defined:
  - `irq` port exists.
  - `irq` is registered as IRQ_EN & TX_DONE, one cycle after either term changes.
  - `irq` stays level-high until TX_DONE is cleared via W1C.
- `AXI_CTRL_IRQ_EN` undefined:
  - There is no `irq` port.
  - CTRL bit1 reads 0 and ignores writes.

## Test plan
- Reset then read 0x08 with NUM_CNTR=4, NUM_SCRATCH=4 -> RDATA=0x4158_0404, RRESP=0. Reads of 0x00 and 0x04 return 0.
- Write 0x00=1 -> `tx_req`=1 one cycle after the write edge. Drive `perf_cntr_in` counter2=0x1234 and pulse `tx_done` -> `tx_req`=0 next cycle. STATUS reads 0x10 and CNTR[2] (0x48) reads 0x1234. Changing `perf_cntr_in` afterwards leaves the read at 0x1234.
- Write 0x10=0xAABBCCDD with WSTRB=4'b0101 after it held 0 -> readback 0x00BB00DD.
- Read 0x3C and write 0x7C -> RRESP=2'b10 with RDATA=0, and BRESP=2'b10.
- Pulse `rd_done` in the same cycle as a W1C write 0x04=0x02 -> RD_DONE remains 1. A second W1C clears it to 0.
- With AXI_CTRL_IRQ_EN: write CTRL=0x3 and complete the transfer -> `irq`=1. W1C 0x10 -> `irq`=0 one cycle later. Hold BREADY=0 for 5 cycles -> BVALID holds and no new AW is accepted.
